// File: rtl/playback_sequencer.sv
// Playback sequencer: walks NUM_CH channels through WAIT/RUN states.
// A play press (or auto-advance) starts a channel; done, abort or the
// optional run timeout ends it. Outputs are a pure decode of the state
// registers, so no input reaches an output combinationally.
module playback_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int TIMEOUT_CYC = 0,
    parameter int TO_W        = 24,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic                done,
    input  logic                abort,
    input  logic                auto_mode,
    output logic [NUM_CH-1:0]   cv,
    output logic [2*NUM_CH-1:0] led,
    output logic [CH_W-1:0]     ch_idx,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } phase_t;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
    // Counter value seen on the last permitted RUN cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

    phase_t          phase_reg;
    logic [CH_W-1:0] ch_reg;
    logic [TO_W-1:0] cnt_reg;
    logic            err_reg;
    logic            play_q_reg;
    logic            play_rise;

    // play_q resets high so a button held through reset release is not an edge.
    assign play_rise = play & ~play_q_reg;

    // Sequencer state, timeout counter and sticky error, in priority order:
    // abort, done, timeout, play edge, hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg  <= S_WAIT;
            ch_reg     <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
            play_q_reg <= 1'b1;
        end else begin
            play_q_reg <= play;
            if (abort) begin
                phase_reg <= S_WAIT;
                ch_reg    <= '0;
                cnt_reg   <= '0;
            end else if (phase_reg == S_RUN && done) begin
                cnt_reg <= '0;
                if (ch_reg != CH_LAST) begin
                    ch_reg    <= ch_reg + CH_W'(1);
                    phase_reg <= auto_mode ? S_RUN : S_WAIT;
                end else begin
                    ch_reg    <= '0;
                    phase_reg <= S_WAIT;
                end
            end else if (phase_reg == S_RUN && TO_EN && cnt_reg == TO_LAST) begin
                phase_reg <= S_WAIT;
                ch_reg    <= '0;
                cnt_reg   <= '0;
                err_reg   <= 1'b1;
            end else if (phase_reg == S_WAIT && play_rise) begin
                phase_reg <= S_RUN;
                cnt_reg   <= '0;
                if (ch_reg == '0) begin
                    err_reg <= 1'b0;
                end
            end else if (phase_reg == S_RUN) begin
                cnt_reg <= cnt_reg + TO_W'(1);
            end
        end
    end

    // Moore decode: channel k owns cv[NUM_CH-1-k] and led[2k] / led[2k+1].
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
            assign cv[NUM_CH-1-gi] = (phase_reg == S_RUN)  && (ch_reg == CH_W'(gi));
            assign led[2*gi]       = (phase_reg == S_WAIT) && (ch_reg == CH_W'(gi));
            assign led[2*gi+1]     = (phase_reg == S_RUN)  && (ch_reg == CH_W'(gi));
        end
    endgenerate

    assign ch_idx      = ch_reg;
    assign busy        = (phase_reg == S_RUN);
    assign timeout_err = err_reg;

endmodule
